// File: rtl/video_timing.sv
// 640x480@60 timing generator advanced by rising edges of the pixel strobe.
// Drives sync, data-enable, coordinates, line/frame pulses and a strobe-loss flag.
module video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       flag_pixel,
    output logic       hsync,
    output logic       vsync,
    output logic       data_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TW      = $clog2(TIMEOUT + 1);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    logic          flag_q;
    logic          tick;
    logic [9:0]    x_nxt;
    logic [9:0]    y_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;

    always_comb begin
        tick  = enable & flag_pixel & ~flag_q;
        x_nxt = x;
        y_nxt = y;
        if (tick) begin
            if (x < X_LAST) begin
                x_nxt = x + 10'd1;
            end else begin
                x_nxt = '0;
                y_nxt = (y < Y_LAST) ? y + 10'd1 : '0;
            end
        end

        tmo_nxt = tmo_cnt;
        if (tick || !enable)
            tmo_nxt = '0;
        else if (tmo_cnt < TMO_MAX)
            tmo_nxt = tmo_cnt + 1'b1;
    end

    // Decodes use the next counter values so they line up with x/y.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            flag_q      <= 1'b0;
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            data_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            tmo_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            flag_q      <= flag_pixel;
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
            vsync       <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
            data_en     <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
            line_start  <= tick && (x_nxt == '0);
            frame_start <= tick && (x_nxt == '0) && (y_nxt == '0);
            tmo_cnt     <= tmo_nxt;
            err         <= err | (tmo_nxt == TMO_MAX);
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: full-size instance for line/enable/loss/reset,
// plus a shrunken instance so whole frames fit in a short run.
module tb_video_timing;

    logic       clk;
    logic       n_rst;
    logic       enable;
    logic       flag_pixel;
    logic       hsync, vsync, data_en, line_start, frame_start, err;
    logic [9:0] x, y;

    logic       enable2;
    logic       flag2;
    logic       hsync2, vsync2, data_en2, line_start2, frame_start2, err2;
    logic [9:0] x2, y2;

    int checks   = 0;
    int failures = 0;

    int ex, ey, ex2, ey2;
    int hlow, vlow2, fs_cnt2, guard;

    video_timing dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .flag_pixel(flag_pixel),
        .hsync(hsync), .vsync(vsync), .data_en(data_en), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .err(err)
    );

    // 8 x 12 frame: hsync low x=5..6, vsync low y=8..9, visible 4 x 6
    video_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .TIMEOUT(16)
    ) dut_small (
        .clk(clk), .n_rst(n_rst), .enable(enable2), .flag_pixel(flag2),
        .hsync(hsync2), .vsync(vsync2), .data_en(data_en2), .x(x2), .y(y2),
        .line_start(line_start2), .frame_start(frame_start2), .err(err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk();
        flag_pixel = 1'b1;
        step();
        if (ex < 799) ex++;
        else begin
            ex = 0;
            ey = (ey < 524) ? ey + 1 : 0;
        end
        chk("x", 32'(x), 32'(ex));
        chk("y", 32'(y), 32'(ey));
        chk("data_en", 32'(data_en), 32'((ex < 640) && (ey < 480)));
        chk("hsync", 32'(hsync), 32'(!((ex >= 656) && (ex <= 751))));
        chk("vsync", 32'(vsync), 32'(!((ey >= 490) && (ey <= 491))));
        chk("line_start", 32'(line_start), 32'(ex == 0));
        chk("frame_start", 32'(frame_start), 32'((ex == 0) && (ey == 0)));
        if (!hsync) hlow++;
        flag_pixel = 1'b0;
        step();
        chk("line_start_drop", 32'(line_start), 32'(0));
    endtask

    task automatic tick_chk2();
        flag2 = 1'b1;
        step();
        if (ex2 < 7) ex2++;
        else begin
            ex2 = 0;
            ey2 = (ey2 < 11) ? ey2 + 1 : 0;
        end
        chk("s_x", 32'(x2), 32'(ex2));
        chk("s_y", 32'(y2), 32'(ey2));
        chk("s_data_en", 32'(data_en2), 32'((ex2 < 4) && (ey2 < 6)));
        chk("s_hsync", 32'(hsync2), 32'(!((ex2 >= 5) && (ex2 <= 6))));
        chk("s_vsync", 32'(vsync2), 32'(!((ey2 >= 8) && (ey2 <= 9))));
        chk("s_line_start", 32'(line_start2), 32'(ex2 == 0));
        chk("s_frame_start", 32'(frame_start2), 32'((ex2 == 0) && (ey2 == 0)));
        if (!vsync2) vlow2++;
        if (frame_start2) fs_cnt2++;
        flag2 = 1'b0;
        step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, 32'(x), 32'(799));
        chk({tag, "_y"}, 32'(y), 32'(524));
        chk({tag, "_hsync"}, 32'(hsync), 32'(1));
        chk({tag, "_vsync"}, 32'(vsync), 32'(1));
        chk({tag, "_data_en"}, 32'(data_en), 32'(0));
        chk({tag, "_line_start"}, 32'(line_start), 32'(0));
        chk({tag, "_frame_start"}, 32'(frame_start), 32'(0));
        chk({tag, "_err"}, 32'(err), 32'(0));
    endtask

    initial begin
        n_rst = 1'b0; enable = 1'b0; flag_pixel = 1'b0;
        enable2 = 1'b0; flag2 = 1'b0;
        hlow = 0; vlow2 = 0; fs_cnt2 = 0;

        // reset with strobe toggling
        flag_pixel = 1'b1; step();
        flag_pixel = 1'b0; step();
        flag_pixel = 1'b1; step();
        chk_reset("rst");
        chk("rst_small_x", 32'(x2), 32'(7));
        chk("rst_small_y", 32'(y2), 32'(11));

        // first ticks at toggle-every-5 rate
        flag_pixel = 1'b0; n_rst = 1'b1; enable = 1'b1;
        repeat (5) step();
        chk("pre_tick_x", 32'(x), 32'(799));
        flag_pixel = 1'b1;
        step();
        chk("t1_x", 32'(x), 32'(0));
        chk("t1_y", 32'(y), 32'(0));
        chk("t1_line_start", 32'(line_start), 32'(1));
        chk("t1_frame_start", 32'(frame_start), 32'(1));
        chk("t1_data_en", 32'(data_en), 32'(1));
        chk("t1_hsync", 32'(hsync), 32'(1));
        chk("t1_vsync", 32'(vsync), 32'(1));
        step();
        chk("t1_ls_width", 32'(line_start), 32'(0));
        chk("t1_fs_width", 32'(frame_start), 32'(0));
        chk("t1_hold_x", 32'(x), 32'(0));
        repeat (3) step();
        flag_pixel = 1'b0;
        repeat (5) step();
        flag_pixel = 1'b1;
        step();
        chk("t2_x", 32'(x), 32'(1));
        chk("t2_line_start", 32'(line_start), 32'(0));
        chk("t2_frame_start", 32'(frame_start), 32'(0));
        repeat (4) step();
        flag_pixel = 1'b0;
        step();
        ex = 1; ey = 0;

        // one full line of ticks
        for (int i = 0; i < 800; i++) tick_chk();
        chk("line_hsync_low_ticks", 32'(hlow), 32'(96));
        chk("line_end_x", 32'(x), 32'(1));
        chk("line_end_y", 32'(y), 32'(1));
        chk("line_err", 32'(err), 32'(0));

        // enable gating, ends with strobe high
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            flag_pixel = ((i / 5) % 2 == 1);
            step();
            chk("gate_x", 32'(x), 32'(ex));
            chk("gate_y", 32'(y), 32'(ey));
            chk("gate_line_start", 32'(line_start), 32'(0));
            chk("gate_err", 32'(err), 32'(0));
        end
        enable = 1'b1;
        step();
        chk("reen_no_tick_x", 32'(x), 32'(ex));
        flag_pixel = 1'b0; step();
        flag_pixel = 1'b1; step();
        ex++;
        chk("reen_tick_x", 32'(x), 32'(ex));
        flag_pixel = 1'b0; step();

        // strobe loss: err exactly 16 clk after the last tick
        flag_pixel = 1'b1; step();
        ex++;
        chk("loss_last_x", 32'(x), 32'(ex));
        flag_pixel = 1'b0;
        repeat (15) step();
        chk("loss_err_15", 32'(err), 32'(0));
        step();
        chk("loss_err_16", 32'(err), 32'(1));
        for (int i = 0; i < 3; i++) tick_chk();
        chk("loss_err_sticky", 32'(err), 32'(1));

        // advance to x=300 then reset mid-frame
        guard = 0;
        while (ex != 300 && guard < 1000) begin
            tick_chk();
            guard++;
        end
        chk("mid_x", 32'(x), 32'(300));
        chk("mid_y", 32'(y), 32'(1));
        flag_pixel = 1'b1;
        n_rst = 1'b0;
        step();
        chk_reset("mid_rst");
        step();
        n_rst = 1'b1;
        step();
        chk("rel_x", 32'(x), 32'(0));
        chk("rel_y", 32'(y), 32'(0));
        chk("rel_frame_start", 32'(frame_start), 32'(1));
        chk("rel_line_start", 32'(line_start), 32'(1));
        chk("rel_data_en", 32'(data_en), 32'(1));
        flag_pixel = 1'b0;
        enable = 1'b0;

        // two whole frames on the small instance
        enable2 = 1'b1;
        ex2 = 7; ey2 = 11;
        for (int i = 0; i < 192; i++) tick_chk2();
        chk("s_vsync_low_ticks", 32'(vlow2), 32'(32));
        chk("s_frame_count", 32'(fs_cnt2), 32'(2));
        chk("s_end_x", 32'(x2), 32'(7));
        chk("s_end_y", 32'(y2), 32'(11));
        chk("s_err", 32'(err2), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
